// File: rtl/rb_window_reader.sv
// Read side of the row-buffer store: one column read per accepted pixel, builds KxK windows.
// Latency: pixel accepted at edge n -> window valid after edge n+1; 1 pixel/cycle unstalled.
// Backpressure: win_valid & ~win_ready freezes everything; pix_ready low, no reads issued.
// Optional macro WIN_COORD_EN adds registered window-centre outputs win_x / win_y.
module rb_window_reader #(
  parameter int PIXEL_BITS   = 8,
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512,
  parameter int KERNEL_SIZE  = 5,
  localparam int RB_COUNT    = KERNEL_SIZE - 1,
  localparam int XW          = $clog2(IMAGE_WIDTH),
  localparam int YW          = $clog2(IMAGE_HEIGHT),
  localparam int SW          = (RB_COUNT > 1) ? $clog2(RB_COUNT) : 1,
  localparam int WW          = PIXEL_BITS * KERNEL_SIZE * KERNEL_SIZE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pix_valid,
  output logic                             pix_ready,
  input  logic [PIXEL_BITS-1:0]            pix_data,
  output logic                             re,
  output logic [XW-1:0]                    read_addr,
  input  logic [PIXEL_BITS*RB_COUNT-1:0]   read_data,
  output logic [SW-1:0]                    wr_slot,
  output logic                             win_valid,
  input  logic                             win_ready,
  output logic [WW-1:0]                    win_data,
`ifdef WIN_COORD_EN
  output logic [XW-1:0]                    win_x,
  output logic [YW-1:0]                    win_y,
`endif
  output logic                             frame_done
);

  localparam int K  = KERNEL_SIZE;
  localparam int PB = PIXEL_BITS;
  localparam logic [XW-1:0] X_MAX = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMAGE_HEIGHT - 1);
  localparam logic [SW-1:0] S_MAX = SW'(RB_COUNT - 1);
  localparam logic [XW-1:0] KM1_X = XW'(K - 1);
  localparam logic [YW-1:0] KM1_Y = YW'(K - 1);
`ifdef WIN_COORD_EN
  localparam logic [XW-1:0] HALF_X = XW'(K / 2);
  localparam logic [YW-1:0] HALF_Y = YW'(K / 2);
`endif

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          s1_vld_q, s1_vld_d;
  logic [PB-1:0] s1_pix_q, s1_pix_d;
  logic [XW-1:0] s1_x_q, s1_x_d;
  logic [YW-1:0] s1_y_q, s1_y_d;
  logic [SW-1:0] s1_slot_q, s1_slot_d;
  logic [WW-1:0] win_q, win_d;
  logic          win_vld_q, win_vld_d;
  logic          fdone_q, fdone_d;
`ifdef WIN_COORD_EN
  logic [XW-1:0] win_x_q, win_x_d;
  logic [YW-1:0] win_y_q, win_y_d;
`endif

  logic en, accept, x_last, y_last;
  logic [PB-1:0] rb_word [RB_COUNT];
  logic [PB-1:0] col [K];

  // Everything advances only when no window is waiting or the waiting one is taken now.
  assign en     = rst & (~win_vld_q | win_ready);
  assign accept = pix_valid & en;
  assign x_last = (x_q == X_MAX);
  assign y_last = (y_q == Y_MAX);

  assign pix_ready  = en;
  assign re         = accept;
  assign read_addr  = x_q;
  assign wr_slot    = slot_q;
  assign win_valid  = win_vld_q;
  assign win_data   = win_q;
  assign frame_done = fdone_q;
`ifdef WIN_COORD_EN
  assign win_x = win_x_q;
  assign win_y = win_y_q;
`endif

  // Column assembly: slot (s1_slot + r) mod RB_COUNT holds the r-th oldest row.
  for (genvar s = 0; s < RB_COUNT; s++) begin : g_word
    assign rb_word[s] = read_data[s*PB +: PB];
  end
  for (genvar r = 0; r < RB_COUNT; r++) begin : g_col
    logic [SW:0] sum;
    assign sum    = {1'b0, s1_slot_q} + (SW+1)'(r);
    assign col[r] = (sum >= (SW+1)'(RB_COUNT)) ? rb_word[SW'(sum - (SW+1)'(RB_COUNT))]
                                               : rb_word[sum[SW-1:0]];
  end
  assign col[K-1] = s1_pix_q;

  // Raster counters and the stage-1 capture of each accepted pixel.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    slot_d    = slot_q;
    s1_vld_d  = s1_vld_q;
    s1_pix_d  = s1_pix_q;
    s1_x_d    = s1_x_q;
    s1_y_d    = s1_y_q;
    s1_slot_d = s1_slot_q;
    fdone_d   = accept & x_last & y_last;
    if (en) s1_vld_d = pix_valid;
    if (accept) begin
      s1_pix_d  = pix_data;
      s1_x_d    = x_q;
      s1_y_d    = y_q;
      s1_slot_d = slot_q;
      if (x_last) begin
        x_d = '0;
        if (y_last) begin
          y_d    = '0;
          slot_d = '0;
        end else begin
          y_d    = y_q + 1'b1;
          slot_d = (slot_q == S_MAX) ? '0 : slot_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Window shift: columns move left, newest column enters at c = K-1.
  always_comb begin
    win_d     = win_q;
    win_vld_d = win_vld_q;
`ifdef WIN_COORD_EN
    win_x_d   = win_x_q;
    win_y_d   = win_y_q;
`endif
    if (en) begin
      if (s1_vld_q) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) begin
            win_d[(r*K+c)*PB +: PB] = win_q[(r*K+c+1)*PB +: PB];
          end
          win_d[(r*K+K-1)*PB +: PB] = col[r];
        end
        // Windows straddling a row or frame edge are never flagged.
        win_vld_d = (s1_x_q >= KM1_X) && (s1_y_q >= KM1_Y);
`ifdef WIN_COORD_EN
        win_x_d   = s1_x_q - HALF_X;
        win_y_d   = s1_y_q - HALF_Y;
`endif
      end else begin
        win_vld_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q       <= '0;
      y_q       <= '0;
      slot_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_pix_q  <= '0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      s1_slot_q <= '0;
      win_q     <= '0;
      win_vld_q <= 1'b0;
      fdone_q   <= 1'b0;
`ifdef WIN_COORD_EN
      win_x_q   <= '0;
      win_y_q   <= '0;
`endif
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      slot_q    <= slot_d;
      s1_vld_q  <= s1_vld_d;
      s1_pix_q  <= s1_pix_d;
      s1_x_q    <= s1_x_d;
      s1_y_q    <= s1_y_d;
      s1_slot_q <= s1_slot_d;
      win_q     <= win_d;
      win_vld_q <= win_vld_d;
      fdone_q   <= fdone_d;
`ifdef WIN_COORD_EN
      win_x_q   <= win_x_d;
      win_y_q   <= win_y_d;
`endif
    end
  end

endmodule

// File: tb/tb_rb_window_reader.sv
// Directed bench for rb_window_reader on an 8x6 frame with a 3x3 kernel.
// Pixel value is y*8+x; a behavioural read-first BRAM sits beside the DUT.
// Define WIN_COORD_EN to also exercise the window-centre outputs.
module tb_rb_window_reader;

  logic        clk;
  logic        rst;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic        re;
  logic [2:0]  read_addr;
  logic [15:0] read_data;
  logic [0:0]  wr_slot;
  logic        win_valid;
  logic        win_ready;
  logic [71:0] win_data;
  logic        frame_done;
`ifdef WIN_COORD_EN
  logic [2:0]  win_x;
  logic [2:0]  win_y;
`endif

  rb_window_reader #(
    .PIXEL_BITS(8), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(6), .KERNEL_SIZE(3)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .re(re), .read_addr(read_addr), .read_data(read_data), .wr_slot(wr_slot),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
`ifdef WIN_COORD_EN
    .win_x(win_x), .win_y(win_y),
`endif
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural two-slot row buffer: registered read, read-first, data held when idle.
  logic [7:0] mem [0:15];
  always @(posedge clk) begin
    if (re) begin
      for (int s = 0; s < 2; s++) read_data[s*8 +: 8] <= mem[s*8 + int'(read_addr)];
      mem[int'(wr_slot)*8 + int'(read_addr)] <= pix_data;
    end
  end

  int ncmp = 0;
  int nfail = 0;
  int bx = 0, by = 0;          // next pixel offered
  int ax = 0, ay = 0;          // last pixel accepted
  logic last_acc = 1'b0;
  logic pre_rdy = 1'b0, pre_re = 1'b0;
  logic [71:0] cons_data = '0;
  int nwin = 0, nfd = 0;

  function automatic logic [71:0] mkwin(input int base);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*8 +: 8] = 8'(base + r*8 + c);
    return w;
  endfunction

  // One clock: drive, sample handshakes before the edge, then sample state after it.
  task automatic cyc(input logic v, input logic wr);
    pix_valid = v;
    win_ready = wr;
    pix_data  = 8'(by*8 + bx);
    #1;
    pre_rdy  = pix_ready;
    pre_re   = re;
    last_acc = pix_valid & pix_ready;
    if (win_valid && win_ready) begin
      nwin++;
      cons_data = win_data;
    end
    if (last_acc) begin
      ax = bx; ay = by;
      if (bx == 7) begin
        bx = 0;
        by = (by == 5) ? 0 : by + 1;
      end else bx++;
    end
    @(posedge clk);
    #1;
    if (frame_done) nfd++;
  endtask

  task automatic run_until(input int tx, input int ty);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc(1'b1, 1'b1);
      if (last_acc && ax == tx && ay == ty) found = 1'b1;
    end
    ncmp++;
    if (!found) begin
      nfail++;
      $display("FAIL run_until: pixel (%0d,%0d) never accepted, got found=%b want 1", tx, ty, found);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    rst = 1'b1;
    bx = 0; by = 0; nwin = 0; nfd = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    ncmp++; if (pre_rdy !== 1'b0) begin nfail++; $display("FAIL rst_pix_ready: got %b want 0", pre_rdy); end
    ncmp++; if (pre_re !== 1'b0) begin nfail++; $display("FAIL rst_re: got %b want 0", pre_re); end
    ncmp++; if (win_valid !== 1'b0) begin nfail++; $display("FAIL rst_win_valid: got %b want 0", win_valid); end
    ncmp++; if (win_data !== 72'd0) begin nfail++; $display("FAIL rst_win_data: got %h want 0", win_data); end
    ncmp++; if (frame_done !== 1'b0) begin nfail++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    ncmp++; if (read_addr !== 3'd0 || wr_slot !== 1'b0) begin
      nfail++; $display("FAIL rst_counters: got x=%0d slot=%0d want 0/0", read_addr, wr_slot);
    end
    rst = 1'b1;
    bx = 0; by = 0; nwin = 0; nfd = 0;
  endtask

  // Stream from frame start to the first valid window and check its timing and contents.
  task automatic check_first_window(input string tag);
    run_until(2, 2);
    ncmp++; if (nwin != 0) begin nfail++; $display("FAIL %s_early: got %0d windows want 0", tag, nwin); end
    ncmp++; if (win_valid !== 1'b0) begin nfail++; $display("FAIL %s_lat1: got win_valid=%b want 0", tag, win_valid); end
    cyc(1'b1, 1'b1);
    ncmp++; if (win_valid !== 1'b1) begin nfail++; $display("FAIL %s_lat2: got win_valid=%b want 1", tag, win_valid); end
    ncmp++; if (win_data !== mkwin(0)) begin nfail++; $display("FAIL %s_data: got %h want %h", tag, win_data, mkwin(0)); end
`ifdef WIN_COORD_EN
    ncmp++; if (win_x !== 3'd1 || win_y !== 3'd1) begin
      nfail++; $display("FAIL %s_coord: got x=%0d y=%0d want 1/1", tag, win_x, win_y);
    end
`endif
  endtask

  task automatic test_first_window();
    do_reset();
    check_first_window("first");
  endtask

  task automatic test_full_frame();
    do_reset();
    run_until(7, 5);
    ncmp++; if (frame_done !== 1'b1) begin nfail++; $display("FAIL fd_pulse: got %b want 1", frame_done); end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
    ncmp++; if (nwin != 24) begin nfail++; $display("FAIL win_count: got %0d want 24", nwin); end
    ncmp++; if (nfd != 1) begin nfail++; $display("FAIL fd_count: got %0d want 1", nfd); end
    ncmp++; if (read_addr !== 3'd0 || wr_slot !== 1'b0) begin
      nfail++; $display("FAIL wrap: got x=%0d slot=%0d want 0/0", read_addr, wr_slot);
    end
  endtask

  // Continues into the second frame without reset; row 3 lives in slot 1.
  task automatic test_rotation();
    run_until(1, 3);
    ncmp++; if (wr_slot !== 1'b1 || read_addr !== 3'd2) begin
      nfail++; $display("FAIL rot_slot: got slot=%0d x=%0d want 1/2", wr_slot, read_addr);
    end
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    ncmp++; if (win_valid !== 1'b1) begin nfail++; $display("FAIL rot_valid: got %b want 1", win_valid); end
    ncmp++; if (win_data !== mkwin(8)) begin nfail++; $display("FAIL rot_data: got %h want %h", win_data, mkwin(8)); end
  endtask

  task automatic test_stall();
    do_reset();
    run_until(2, 2);
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      ncmp++; if (pre_rdy !== 1'b0 || pre_re !== 1'b0) begin
        nfail++; $display("FAIL stall_rdy_re[%0d]: got rdy=%b re=%b want 0/0", i, pre_rdy, pre_re);
      end
      ncmp++; if (win_valid !== 1'b1 || win_data !== mkwin(0)) begin
        nfail++; $display("FAIL stall_hold[%0d]: got v=%b %h want 1 %h", i, win_valid, win_data, mkwin(0));
      end
    end
    cyc(1'b1, 1'b1);
    ncmp++; if (cons_data !== mkwin(0) || last_acc !== 1'b1) begin
      nfail++; $display("FAIL release_consume: got %h acc=%b want %h acc=1", cons_data, last_acc, mkwin(0));
    end
    ncmp++; if (win_valid !== 1'b1 || win_data !== mkwin(1)) begin
      nfail++; $display("FAIL release_next: got v=%b %h want 1 %h", win_valid, win_data, mkwin(1));
    end
  endtask

  task automatic test_reset_midrow();
    run_until(3, 3);
    rst = 1'b0;
    cyc(1'b1, 1'b1);
    ncmp++; if (pre_rdy !== 1'b0) begin nfail++; $display("FAIL midrst_rdy_pre: got %b want 0", pre_rdy); end
    ncmp++; if (win_valid !== 1'b0 || pix_ready !== 1'b0) begin
      nfail++; $display("FAIL midrst_state: got v=%b rdy=%b want 0/0", win_valid, pix_ready);
    end
    rst = 1'b1;
    bx = 0; by = 0; nwin = 0; nfd = 0;
    check_first_window("restart");
  endtask

  initial begin
    rst = 1'b0; pix_valid = 1'b0; win_ready = 1'b1; pix_data = '0;
    test_reset();
    test_first_window();
    test_full_frame();
    test_rotation();
    test_stall();
    test_reset_midrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
